mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive lost arbitrations before the CPU is forced to win.
REQ-002 ext_clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU access request, level, held until cpu_ack.
REQ-005 cpu_we  input  1  CPU write enable, qualified by cpu_req.
REQ-006 cpu_addr  input  16  CPU word address.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_ack  output  1  one-cycle pulse: CPU access complete.
REQ-009 cpu_rdata  output  16  CPU read data, valid when cpu_ack=1, held otherwise.
REQ-010 vga_req  input  1  display fetch request (read-only), level, held until vga_ack.
REQ-011 vga_addr  input  16  display fetch word address.
REQ-012 vga_ack  output  1  one-cycle pulse: fetch complete.
REQ-013 vga_rdata  output  16  fetch data, valid when vga_ack=1, held otherwise.
REQ-014 mem_en  output  1  registered memory enable to the single-port synchronous RAM.
REQ-015 mem_we  output  1  registered memory write enable.
REQ-016 mem_addr  output  16  registered memory address.
REQ-017 mem_wdata  output  16  registered memory write data.
REQ-018 mem_rdata  input  16  RAM read data, valid one cycle after mem_en sampled.

Function
REQ-019 At most one access SHALL be issued per clock; issue at edge E drives mem_* from E, RAM samples at E+1, and ack plus captured rdata SHALL assert at edge E+2 (fixed 2-cycle latency).
REQ-020 Each requester SHALL have an outstanding flag: set at its issue edge E, cleared at its ack edge E+2; a requester with outstanding=1 SHALL be ineligible, so the earliest re-issue is E+3.
REQ-021 Eligible = req && !outstanding; if only one is eligible, it SHALL be issued.
REQ-022 If both are eligible, VGA SHALL win unless starve_cnt == STARVE_MAX, in which case CPU SHALL win.
REQ-023 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment each cycle the CPU is eligible and not issued, saturate at STARVE_MAX, and clear to 0 on CPU issue or when cpu_req=0.
REQ-024 With no eligible requester, mem_en and mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-025 VGA issues SHALL drive mem_we=0; CPU issues SHALL drive mem_we=cpu_we and mem_wdata=cpu_wdata.
REQ-026 On a CPU write, cpu_ack SHALL pulse at E+2 and cpu_rdata SHALL hold its previous value.
REQ-027 Pipelined interleave (CPU issued at E, VGA at E+1) SHALL be legal; each ack returns at its own E+2 with its own data.
REQ-028 cpu_ack and vga_ack SHALL never be high for more than one cycle per issue.
REQ-029 A request withdrawn before issue SHALL be ignored; withdrawal while outstanding SHALL NOT cancel the ack.

Reset
REQ-030 While reset=1: mem_en, mem_we, cpu_ack, vga_ack = 0; mem_addr, mem_wdata, cpu_rdata, vga_rdata = 16'h0000; outstanding flags and starve_cnt = 0.
REQ-031 Reset asserted mid-access SHALL drop the in-flight ack; after release, arbitration SHALL restart at the first edge with no stale ack.

Verification
REQ-032 CPU read addr 16'h0010 (RAM holds 16'hBEEF), VGA idle -> mem_en=1 at E, cpu_ack=1 and cpu_rdata=16'hBEEF at E+2, no re-issue before E+3.
REQ-033 CPU write addr 16'h0020 data 16'h1234, then read same -> mem_we=1 on first issue only; read returns 16'h1234.
REQ-034 Both requests held continuously, STARVE_MAX=4 -> VGA wins while CPU is starved; CPU issued once starve_cnt reaches 4; starve_cnt returns to 0; no cycle has two issues.
REQ-035 CPU issued at E, VGA requests at E+1 -> VGA issued at E+1; cpu_ack at E+2, vga_ack at E+3, each with correct data.
REQ-036 Reset pulsed at E+1 after a CPU issue at E -> no cpu_ack at E+2; all outputs at reset values; a fresh request after release completes normally.
REQ-037 cpu_req dropped one cycle before it would win -> no issue, starve_cnt=0, mem_en=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of one synchronous single-port RAM. The VGA fetch has
// priority, and the CPU is forced through after STARVE_MAX lost arbitrations.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        ext_clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        vga_req,
    input  logic [15:0] vga_addr,
    output logic        vga_ack,
    output logic [15:0] vga_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    // Handshake: a requester holds req (and its fields) as a level until its ack.
    // An issue at edge E drives mem_* from E, the RAM samples at E+1, and ack plus
    // captured read data appear at E+2. A requester is ineligible from E through E+2.
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic          cpu_out, vga_out;
    logic [CW-1:0] starve_cnt;
    logic          iss_cpu;
    logic          rd_valid, rd_cpu, rd_we;
    logic          cpu_elig, vga_elig, cpu_win, vga_win;

    always_comb begin
        cpu_elig = cpu_req && !cpu_out;
        vga_elig = vga_req && !vga_out;
        cpu_win  = cpu_elig && (!vga_elig || (starve_cnt == CNT_MAX));
        vga_win  = vga_elig && !cpu_win;
    end

    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            iss_cpu    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_cpu     <= 1'b0;
            rd_we      <= 1'b0;
            cpu_ack    <= 1'b0;
            vga_ack    <= 1'b0;
            cpu_rdata  <= 16'h0000;
            vga_rdata  <= 16'h0000;
            cpu_out    <= 1'b0;
            vga_out    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            mem_en  <= cpu_win || vga_win;
            mem_we  <= cpu_win && cpu_we;
            iss_cpu <= cpu_win;
            if (cpu_win) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (vga_win) begin
                mem_addr  <= vga_addr;
            end

            // Second stage: the RAM has sampled the access issued one edge ago.
            rd_valid <= mem_en;
            rd_cpu   <= iss_cpu;
            rd_we    <= mem_we;

            cpu_ack <= rd_valid && rd_cpu;
            vga_ack <= rd_valid && !rd_cpu;
            if (rd_valid && rd_cpu && !rd_we) cpu_rdata <= mem_rdata;
            if (rd_valid && !rd_cpu)          vga_rdata <= mem_rdata;

            if (cpu_win)                    cpu_out <= 1'b1;
            else if (rd_valid && rd_cpu)    cpu_out <= 1'b0;
            if (vga_win)                    vga_out <= 1'b1;
            else if (rd_valid && !rd_cpu)   vga_out <= 1'b0;

            if (!cpu_req || cpu_win)                  starve_cnt <= '0;
            else if (cpu_elig && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural RAM, a transaction-level reference model
// with expected-data queues, directed scenarios and then randomized traffic.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        ext_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vga_req = 1'b0;
    logic [15:0] vga_addr = '0;
    logic        vga_ack;
    logic [15:0] vga_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .ext_clk(ext_clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // clock / reset
    always #5 ext_clk = ~ext_clk;

    // behavioural synchronous RAM, low 8 address bits decoded
    logic [15:0] ram [0:255];
    always @(posedge ext_clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    // reference model state
    logic [15:0] shadow [0:255];
    logic [15:0] cpu_exp_q[$];
    logic [15:0] vga_exp_q[$];
    int          cyc = 0;
    int          cpu_due, vga_due, m_cnt;
    logic        cpu_due_rd;
    logic        pw_valid;
    logic [7:0]  pw_addr;
    logic [15:0] pw_data;
    logic        e_mem_en, e_mem_we, e_cpu_ack, e_vga_ack;
    logic [15:0] e_mem_addr, e_mem_wdata, e_cpu_rdata, e_vga_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    task automatic model_reset();
        cpu_due = -1; vga_due = -1; m_cnt = 0; cpu_due_rd = 1'b0; pw_valid = 1'b0;
        e_mem_en = 1'b0; e_mem_we = 1'b0; e_cpu_ack = 1'b0; e_vga_ack = 1'b0;
        e_mem_addr = '0; e_mem_wdata = '0; e_cpu_rdata = '0; e_vga_rdata = '0;
        cpu_exp_q.delete();
        vga_exp_q.delete();
    endtask

    // One rising edge of the arbitration rules, evaluated on transactions.
    task automatic model_step();
        bit cb, vb, ce, ve, pc, pv;
        cyc++;
        if (reset) begin model_reset(); return; end
        if (pw_valid) begin shadow[pw_addr] = pw_data; pw_valid = 1'b0; end
        cb = (cpu_due >= 0);
        vb = (vga_due >= 0);
        ce = cpu_req && !cb;
        ve = vga_req && !vb;
        pc = ce && (!ve || m_cnt == STARVE_MAX);
        pv = ve && !pc;
        e_cpu_ack = 1'b0;
        e_vga_ack = 1'b0;
        if (cpu_due == cyc) begin
            e_cpu_ack = 1'b1;
            if (cpu_due_rd && cpu_exp_q.size() > 0) e_cpu_rdata = cpu_exp_q.pop_front();
            cpu_due = -1;
        end
        if (vga_due == cyc) begin
            e_vga_ack = 1'b1;
            if (vga_exp_q.size() > 0) e_vga_rdata = vga_exp_q.pop_front();
            vga_due = -1;
        end
        if (!cpu_req || pc) m_cnt = 0;
        else if (ce)        m_cnt = (m_cnt < STARVE_MAX) ? m_cnt + 1 : STARVE_MAX;
        e_mem_en = pc || pv;
        e_mem_we = pc && cpu_we;
        if (pc) begin
            e_mem_addr  = cpu_addr;
            e_mem_wdata = cpu_wdata;
            cpu_due     = cyc + 2;
            cpu_due_rd  = !cpu_we;
            if (cpu_we) begin
                pw_valid = 1'b1; pw_addr = cpu_addr[7:0]; pw_data = cpu_wdata;
            end else begin
                cpu_exp_q.push_back(shadow[cpu_addr[7:0]]);
            end
        end else if (pv) begin
            e_mem_addr = vga_addr;
            vga_due    = cyc + 2;
            vga_exp_q.push_back(shadow[vga_addr[7:0]]);
        end
    endtask

    task automatic compare_all();
        check("mem_en",     16'(mem_en),   16'(e_mem_en));
        check("mem_we",     16'(mem_we),   16'(e_mem_we));
        check("mem_addr",   mem_addr,      e_mem_addr);
        check("mem_wdata",  mem_wdata,     e_mem_wdata);
        check("cpu_ack",    16'(cpu_ack),  16'(e_cpu_ack));
        check("cpu_rdata",  cpu_rdata,     e_cpu_rdata);
        check("vga_ack",    16'(vga_ack),  16'(e_vga_ack));
        check("vga_rdata",  vga_rdata,     e_vga_rdata);
        check("starve_cnt", 16'(dut.starve_cnt), 16'(m_cnt));
    endtask

    // driver tasks
    task automatic cycle(input logic cr, input logic cw, input logic [15:0] ca,
                         input logic [15:0] cd, input logic vr, input logic [15:0] va);
        @(negedge ext_clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        vga_req = vr; vga_addr = va;
        @(posedge ext_clk);
        model_step();
        #1 compare_all();
    endtask

    task automatic assert_reset();
        @(negedge ext_clk);
        reset = 1'b1;
        model_reset();
        #1 compare_all();
    endtask

    task automatic release_reset();
        @(negedge ext_clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 16'(i * 3) ^ 16'h5A5A;
            shadow[i] = 16'(i * 3) ^ 16'h5A5A;
        end
        ram[8'h10]    = 16'hBEEF;
        shadow[8'h10] = 16'hBEEF;
        model_reset();

        // reset state
        #1 compare_all();
        cycle(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 16'h0002);
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        release_reset();

        // CPU read of a known word, VGA idle
        for (int i = 0; i < 4; i++) cycle(i < 3, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0);
        check("beef_rdata", cpu_rdata, 16'hBEEF);

        // write then read back the same address
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) cycle(i < 3, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h0);
        check("wr_rd_rdata", cpu_rdata, 16'h1234);

        // both held continuously
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 16'h0005, 16'h0, 1'b1, 16'h0006);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

        // pipelined interleave: CPU issued, VGA requests the next cycle
        cycle(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 16'h0007);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0003, 16'h0, i < 3, 16'h0007);
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

        // reset right after a CPU issue drops the in-flight ack
        cycle(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0);
        assert_reset();
        check("rst_cpu_ack", 16'(cpu_ack), 16'h0);
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        check("rst_no_ack", 16'(cpu_ack), 16'h0);
        release_reset();
        for (int i = 0; i < 4; i++) cycle(i < 3, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0);
        check("post_rst_rdata", cpu_rdata, 16'hBEEF);

        // CPU loses to VGA, then withdraws before it would win
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0004, 16'h0, 1'b1, 16'h0008);
        cycle(1'b0, 1'b0, 16'h0004, 16'h0, 1'b0, 16'h0);
        check("drop_cnt", 16'(dut.starve_cnt), 16'h0);
        check("drop_mem_en", 16'(mem_en), 16'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

        // randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                assert_reset();
                cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
                release_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      16'($urandom_range(0, 31)), 16'($urandom),
                      $urandom_range(0, 3) != 0, 16'($urandom_range(0, 31)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
